piradip_fifo_axis_reader: RTL and testbench
===========================================

Name: piradip_fifo_axis_reader

Overview:
- Read-side adapter placed directly downstream of the team's synchronous FIFO.
- Drives the FIFO read enable, absorbs the FIFO's fixed read latency, and presents the data as an AXI4-Stream master.
- Holds data in a small prefetch buffer, so a full-rate stream is sustained with no combinational path from m_axis_tready to fifo_re.
- Optionally generates tlast at fixed packet boundaries.

Parameters:
- WIDTH, 32, data width; must equal the FIFO data width.
- READ_LATENCY, 1, FIFO read latency in cycles; legal range 1..4.
- BUF_DEPTH, 3, prefetch buffer entries; must be ≥ READ_LATENCY+1, and ≥ READ_LATENCY+2 for 1 beat/cycle.
- PACKET_LEN, 0, beats per packet; 0 means m_axis_tlast is tied to 0.

Ports:
- clk  in  1  single clock, shared with the FIFO.
- rstn  in  1  asynchronous, active-low reset.
- fifo_re  out  1  FIFO read enable.
- fifo_dout  in  WIDTH  FIFO read data.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_rst_busy  in  1  FIFO read-side reset in progress.
- m_axis_tdata  out  WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  packet end.
- buf_count  out  $clog2(BUF_DEPTH+1)  current prefetch buffer occupancy.

Behaviour:
- Reset (rstn low, asynchronous): the following clear immediately:
  - in-flight counter and latency valid shift register
  - buffer read/write pointers and count
  - beat counter
  - fifo_re=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, buf_count=0
- Reset release is synchronous to clk.
- Reset mid-operation: in-flight and buffered data are discarded. The FIFO is reset by the system with the same reset.
- Read issue (registered, no path from m_axis_tready):
  - fifo_re = !fifo_empty && !fifo_rd_rst_busy && (buf_count + inflight < BUF_DEPTH).
  - inflight = number of reads issued whose data has not yet been captured.
- Capture:
  - A read issued in cycle c has valid fifo_dout in cycle c+READ_LATENCY.
  - Tracking uses a READ_LATENCY-deep valid shift register.
  - Data is written into the buffer at the end of that cycle; inflight decrements in the same cycle.
- Buffer:
  - Circular, BUF_DEPTH entries; the head entry drives m_axis_tdata.
  - m_axis_tvalid = (buf_count != 0).
  - Handshake (tvalid && tready) pops the head.
  - Capture and pop in the same cycle leave buf_count unchanged.
  - Pointers wrap modulo BUF_DEPTH.
  - Overflow cannot occur by construction; the simulation assertion is buf_count + inflight ≤ BUF_DEPTH.
- Latency:
  - FIFO goes non-empty in cycle 0 with the buffer idle: fifo_re=1 in cycle 0, m_axis_tvalid=1 in cycle READ_LATENCY+1.
- Throughput:
  - With BUF_DEPTH ≥ READ_LATENCY+2 and tready held high, one beat per cycle in steady state.
  - With BUF_DEPTH = READ_LATENCY+1, one beat every two cycles.
- AXIS rules:
  - Once m_axis_tvalid is asserted, tdata and tlast stay stable until the handshake.
  - tvalid never depends on tready.
- tlast:
  - The beat counter increments on each handshake and wraps to 0 after PACKET_LEN-1.
  - m_axis_tlast = (PACKET_LEN>0) && (beat counter == PACKET_LEN-1) && m_axis_tvalid.
- Boundaries:
  - fifo_empty asserts while reads are in flight: already-issued reads still complete and are captured.
  - No read is issued while fifo_empty or fifo_rd_rst_busy is high, so there is no FIFO underflow.
  - Backpressure (tready=0): the buffer fills to BUF_DEPTH, then fifo_re stays 0. No data is lost or duplicated.
  - When tready returns, reads resume the cycle after the first pop frees a slot.

Test Plan:
- Reset/idle: rstn low with fifo_empty=1 → all outputs 0, buf_count=0; after release fifo_re stays 0.
- Latency (READ_LATENCY=1, BUF_DEPTH=3): write 8 words 0x00..0x07 with tready=1 → first tvalid 2 cycles after fifo_re; then 8 consecutive beats, in order, one per cycle, and fifo_re=0 once empty.
- Backpressure: 16 words, tready=0 for 10 cycles → buf_count saturates at 3, fifo_re=0, tdata held at 0x00. Release tready → words 0x00..0x0F delivered in order with no gaps after refill.
- Random tready (50%), READ_LATENCY=2, BUF_DEPTH=4, 1000 words → scoreboard exact order, zero loss, assertion never fires.
- Packets: PACKET_LEN=4, 12 words → tlast high on beats 3, 7 and 11 only, including when tready is stalled on a tlast beat.
- Reset mid-stream: rstn low after 5 of 10 beats with reads in flight → tvalid=0 immediately, buf_count=0, beat counter 0; after the FIFO refills with 0xA0.., the first beat is 0xA0 with the correct tlast phase.

Source files
------------

// File: rtl/piradip_fifo_axis_reader_if.sv
// AXI4-Stream bundle used between the FIFO reader and its downstream consumer.
// The master drives data, valid and last; the slave returns ready.
interface piradip_fifo_axis_reader_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/piradip_fifo_axis_reader.sv
// Read-side adapter for a fixed-latency synchronous FIFO: issues reads, absorbs the read latency
// in a small circular prefetch buffer and presents the data as an AXI4-Stream master.
module piradip_fifo_axis_reader #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned BUF_DEPTH    = 3,
  parameter int unsigned PACKET_LEN   = 0
) (
  input  logic                           clk,
  input  logic                           rstn,
  output logic                           fifo_re,
  input  logic [WIDTH-1:0]               fifo_dout,
  input  logic                           fifo_empty,
  input  logic                           fifo_rd_rst_busy,
  piradip_fifo_axis_reader_if.master     m_axis,
  output logic [$clog2(BUF_DEPTH+1)-1:0] buf_count
);

  localparam int unsigned CntW  = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PtrW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned InfW  = $clog2(READ_LATENCY + 1);
  localparam int unsigned BeatW = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;

  localparam logic [PtrW-1:0]  LastPtr  = PtrW'(BUF_DEPTH - 1);
  localparam logic [BeatW-1:0] LastBeat = BeatW'((PACKET_LEN > 0) ? PACKET_LEN - 1 : 0);

  logic                    r_rst_done;
  logic [READ_LATENCY-1:0] r_valid_sr;
  logic [InfW-1:0]         r_inflight;
  logic [WIDTH-1:0]        r_mem [BUF_DEPTH];
  logic [PtrW-1:0]         r_wptr;
  logic [PtrW-1:0]         r_rptr;
  logic [CntW-1:0]         r_count;
  logic [BeatW-1:0]        r_beat;

  logic        w_capture;
  logic        w_pop;
  logic        w_tvalid;
  logic [31:0] w_occupancy;

  function automatic logic [PtrW-1:0] f_ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // Reads are only issued from registered state and FIFO flags, never from tready.
  assign w_occupancy = 32'(r_count) + 32'(r_inflight);
  assign fifo_re     = r_rst_done && !fifo_empty && !fifo_rd_rst_busy &&
                       (w_occupancy < BUF_DEPTH);

  assign w_capture = r_valid_sr[READ_LATENCY-1];
  assign w_tvalid  = (r_count != '0);
  assign w_pop     = w_tvalid && m_axis.tready;

  assign m_axis.tvalid = w_tvalid;
  assign m_axis.tdata  = w_tvalid ? r_mem[r_rptr] : '0;
  assign m_axis.tlast  = (PACKET_LEN > 0) && (r_beat == LastBeat) && w_tvalid;
  assign buf_count     = r_count;

  // Holds off reads for the first cycle after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid_sr <= '0;
      r_inflight <= '0;
    end else begin
      r_valid_sr <= (r_valid_sr << 1) | READ_LATENCY'(fifo_re);
      case ({fifo_re, w_capture})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_mem[r_wptr] <= fifo_dout;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_capture) begin
        r_wptr <= f_ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= f_ptr_inc(r_rptr);
      end
      case ({w_capture, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_beat <= '0;
    end else if (w_pop) begin
      r_beat <= (r_beat == LastBeat) ? '0 : r_beat + 1'b1;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    w_occupancy <= BUF_DEPTH);

  a_axis_stable: assert property (@(posedge clk) disable iff (!rstn)
    (w_tvalid && !m_axis.tready) |=>
      (w_tvalid && $stable(m_axis.tdata) && $stable(m_axis.tlast)));

endmodule

// File: tb/tb_piradip_fifo_axis_reader.sv
// Bench for piradip_fifo_axis_reader: two instances (latency 1 with 4-beat packets, latency 2
// without packets) each fed by a behavioural fixed-latency FIFO and checked against a queue.
module tb_piradip_fifo_axis_reader;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: READ_LATENCY=1, BUF_DEPTH=3, PACKET_LEN=4
  logic        a_re;
  logic        a_empty;
  logic        a_busy = 1'b0;
  logic [31:0] a_dout = '0;
  logic [1:0]  a_cnt;
  logic [31:0] a_mem [2048];
  int unsigned a_wp = 0;
  int unsigned a_rp = 0;
  logic        a_uflow = 1'b0;
  logic [31:0] a_exp [$];
  int          a_beat = 0;

  // Instance B: READ_LATENCY=2, BUF_DEPTH=4, PACKET_LEN=0
  logic        b_re;
  logic        b_empty;
  logic        b_busy = 1'b0;
  logic [31:0] b_d1 = '0;
  logic [31:0] b_dout = '0;
  logic [2:0]  b_cnt;
  logic [31:0] b_mem [2048];
  int unsigned b_wp = 0;
  int unsigned b_rp = 0;
  logic        b_uflow = 1'b0;
  logic [31:0] b_exp [$];

  piradip_fifo_axis_reader_if #(.WIDTH(32)) a_ax ();
  piradip_fifo_axis_reader_if #(.WIDTH(32)) b_ax ();

  piradip_fifo_axis_reader #(
    .WIDTH(32), .READ_LATENCY(1), .BUF_DEPTH(3), .PACKET_LEN(4)
  ) u_dut_a (
    .clk(clk), .rstn(rstn), .fifo_re(a_re), .fifo_dout(a_dout), .fifo_empty(a_empty),
    .fifo_rd_rst_busy(a_busy), .m_axis(a_ax), .buf_count(a_cnt)
  );

  piradip_fifo_axis_reader #(
    .WIDTH(32), .READ_LATENCY(2), .BUF_DEPTH(4), .PACKET_LEN(0)
  ) u_dut_b (
    .clk(clk), .rstn(rstn), .fifo_re(b_re), .fifo_dout(b_dout), .fifo_empty(b_empty),
    .fifo_rd_rst_busy(b_busy), .m_axis(b_ax), .buf_count(b_cnt)
  );

  assign a_empty = (a_wp == a_rp);
  assign b_empty = (b_wp == b_rp);

  // FIFO models; the system reset empties them.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_rp <= a_wp;
    end else if (a_re) begin
      if (a_wp == a_rp) a_uflow <= 1'b1;
      else begin
        a_dout <= a_mem[a_rp[10:0]];
        a_rp   <= a_rp + 1;
      end
    end
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      b_rp <= b_wp;
    end else begin
      b_d1   <= b_mem[b_rp[10:0]];
      b_dout <= b_d1;
      if (b_re) begin
        if (b_wp == b_rp) b_uflow <= 1'b1;
        else b_rp <= b_rp + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [31:0] w);
    a_mem[a_wp[10:0]] = w;
    a_wp = a_wp + 1;
    a_exp.push_back(w);
  endtask

  task automatic push_b(input logic [31:0] w);
    b_mem[b_wp[10:0]] = w;
    b_wp = b_wp + 1;
    b_exp.push_back(w);
  endtask

  task automatic test_reset();
    a_ax.tready = 1'b0;
    b_ax.tready = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_re, a_ax.tvalid, a_ax.tlast, a_ax.tdata, a_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_a: re=%b v=%b l=%b d=%h cnt=%0d, want all 0",
               a_re, a_ax.tvalid, a_ax.tlast, a_ax.tdata, a_cnt);
    end
    checks++;
    if ({b_re, b_ax.tvalid, b_ax.tlast, b_ax.tdata, b_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_b: re=%b v=%b d=%h cnt=%0d, want all 0",
               b_re, b_ax.tvalid, b_ax.tdata, b_cnt);
    end
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (a_re !== 1'b0 || a_ax.tvalid !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset: re=%b v=%b, want 0 0", a_re, a_ax.tvalid);
      end
      tick();
    end
  endtask

  task automatic test_latency();
    int first_re = -1;
    int first_v  = -1;
    int gaps     = 0;
    logic [31:0] exp;
    a_ax.tready = 1'b1;
    for (int i = 0; i < 8; i++) push_a(32'(i));
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (a_re && first_re < 0) first_re = cyc;
      if (a_ax.tvalid && first_v < 0) first_v = cyc;
      if (first_v >= 0 && a_exp.size() > 0 && !a_ax.tvalid) gaps++;
      if (a_ax.tvalid && a_ax.tready) begin
        if (a_exp.size() == 0) begin
          errors++;
          $display("FAIL lat_extra_beat: got %h, want no beat", a_ax.tdata);
        end else begin
          exp = a_exp.pop_front();
          checks++;
          if (a_ax.tdata !== exp) begin
            errors++;
            $display("FAIL lat_data: got %h want %h", a_ax.tdata, exp);
          end
          checks++;
          if (a_ax.tlast !== (a_beat == 3)) begin
            errors++;
            $display("FAIL lat_tlast: got %b want %b", a_ax.tlast, a_beat == 3);
          end
          a_beat = (a_beat + 1) % 4;
        end
      end
      tick();
    end
    checks++;
    if (first_v - first_re !== 2) begin
      errors++;
      $display("FAIL lat_first_valid: re@%0d valid@%0d, want 2 cycles apart", first_re, first_v);
    end
    checks++;
    if (gaps !== 0) begin
      errors++;
      $display("FAIL lat_gaps: got %0d idle cycles, want 0", gaps);
    end
    checks++;
    if (a_exp.size() !== 0) begin
      errors++;
      $display("FAIL lat_timeout: %0d beats missing, want 0", a_exp.size());
    end
    @(negedge clk);
    checks++;
    if (a_re !== 1'b0) begin
      errors++;
      $display("FAIL lat_re_when_empty: got %b want 0", a_re);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int gaps    = 0;
    int started = 0;
    logic [31:0] exp;
    a_ax.tready = 1'b0;
    for (int i = 0; i < 16; i++) push_a(32'(i));
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (cyc >= 5) begin
        checks++;
        if (a_cnt !== 2'd3 || a_re !== 1'b0 || a_ax.tvalid !== 1'b1 || a_ax.tdata !== 32'h0) begin
          errors++;
          $display("FAIL bp_hold: cnt=%0d re=%b v=%b d=%h, want 3 0 1 00000000",
                   a_cnt, a_re, a_ax.tvalid, a_ax.tdata);
        end
      end
      tick();
    end
    a_ax.tready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        checks++;
        if (a_re !== 1'b0) begin
          errors++;
          $display("FAIL bp_release_re0: got %b want 0", a_re);
        end
      end
      if (cyc == 1) begin
        checks++;
        if (a_re !== 1'b1) begin
          errors++;
          $display("FAIL bp_resume_re: got %b want 1", a_re);
        end
      end
      if (a_ax.tvalid) started = 1;
      if (started != 0 && a_exp.size() > 0 && !a_ax.tvalid) gaps++;
      if (a_ax.tvalid && a_ax.tready) begin
        if (a_exp.size() == 0) begin
          errors++;
          $display("FAIL bp_extra_beat: got %h, want no beat", a_ax.tdata);
        end else begin
          exp = a_exp.pop_front();
          checks++;
          if (a_ax.tdata !== exp || a_ax.tlast !== (a_beat == 3)) begin
            errors++;
            $display("FAIL bp_data: got %h/%b want %h/%b", a_ax.tdata, a_ax.tlast, exp,
                     a_beat == 3);
          end
          a_beat = (a_beat + 1) % 4;
        end
      end
      tick();
    end
    checks++;
    if (gaps !== 0 || a_exp.size() !== 0) begin
      errors++;
      $display("FAIL bp_drain: gaps=%0d missing=%0d, want 0 0", gaps, a_exp.size());
    end
  endtask

  task automatic test_packets();
    int hold = 0;
    int lasts = 0;
    logic [31:0] exp;
    for (int i = 0; i < 12; i++) push_a(32'h100 + 32'(i));
    for (int cyc = 0; cyc < 80; cyc++) begin
      // Stall every tlast beat for two cycles.
      if (a_ax.tvalid && a_ax.tlast && hold < 2) begin
        a_ax.tready = 1'b0;
        hold++;
      end else begin
        a_ax.tready = 1'b1;
      end
      @(negedge clk);
      if (a_ax.tvalid) begin
        checks++;
        if (a_ax.tlast !== (a_beat == 3)) begin
          errors++;
          $display("FAIL pkt_tlast: beat %0d got %b want %b", a_beat, a_ax.tlast, a_beat == 3);
        end
      end
      if (a_ax.tvalid && a_ax.tready) begin
        if (a_exp.size() == 0) begin
          errors++;
          $display("FAIL pkt_extra_beat: got %h, want no beat", a_ax.tdata);
        end else begin
          exp = a_exp.pop_front();
          checks++;
          if (a_ax.tdata !== exp) begin
            errors++;
            $display("FAIL pkt_data: got %h want %h", a_ax.tdata, exp);
          end
          if (a_ax.tlast) begin
            lasts++;
            hold = 0;
          end
          a_beat = (a_beat + 1) % 4;
        end
      end
      tick();
    end
    a_ax.tready = 1'b1;
    checks++;
    if (lasts !== 3 || a_exp.size() !== 0) begin
      errors++;
      $display("FAIL pkt_count: tlast beats=%0d missing=%0d, want 3 0", lasts, a_exp.size());
    end
  endtask

  task automatic test_rd_rst_busy();
    logic [31:0] exp;
    a_busy = 1'b1;
    push_a(32'h55);
    push_a(32'h66);
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      checks++;
      if (a_re !== 1'b0 || a_ax.tvalid !== 1'b0) begin
        errors++;
        $display("FAIL busy_block: re=%b v=%b, want 0 0", a_re, a_ax.tvalid);
      end
      tick();
    end
    a_busy = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (a_ax.tvalid && a_ax.tready && a_exp.size() > 0) begin
        exp = a_exp.pop_front();
        checks++;
        if (a_ax.tdata !== exp || a_ax.tlast !== (a_beat == 3)) begin
          errors++;
          $display("FAIL busy_data: got %h/%b want %h/%b", a_ax.tdata, a_ax.tlast, exp,
                   a_beat == 3);
        end
        a_beat = (a_beat + 1) % 4;
      end
      tick();
    end
    checks++;
    if (a_exp.size() !== 0 || a_uflow !== 1'b0) begin
      errors++;
      $display("FAIL busy_drain: missing=%0d underflow=%b, want 0 0", a_exp.size(), a_uflow);
    end
  endtask

  task automatic test_reset_mid();
    int beats = 0;
    logic [31:0] exp;
    for (int i = 0; i < 10; i++) push_a(32'h10 + 32'(i));
    for (int cyc = 0; cyc < 40 && beats < 5; cyc++) begin
      @(negedge clk);
      if (a_ax.tvalid && a_ax.tready && a_exp.size() > 0) begin
        exp = a_exp.pop_front();
        checks++;
        if (a_ax.tdata !== exp || a_ax.tlast !== (a_beat == 3)) begin
          errors++;
          $display("FAIL mid_pre_data: got %h/%b want %h/%b", a_ax.tdata, a_ax.tlast, exp,
                   a_beat == 3);
        end
        a_beat = (a_beat + 1) % 4;
        beats++;
      end
      if (beats < 5) tick();
    end
    @(posedge clk);
    #2;
    checks++;
    if (a_ax.tvalid !== 1'b1 || beats !== 5) begin
      errors++;
      $display("FAIL mid_pre_valid: v=%b beats=%0d, want 1 5", a_ax.tvalid, beats);
    end
    #1;
    rstn = 1'b0;
    #1;
    checks++;
    if ({a_re, a_ax.tvalid, a_ax.tlast, a_ax.tdata, a_cnt} !== '0) begin
      errors++;
      $display("FAIL mid_reset: re=%b v=%b l=%b d=%h cnt=%0d, want all 0",
               a_re, a_ax.tvalid, a_ax.tlast, a_ax.tdata, a_cnt);
    end
    a_exp.delete();
    a_beat = 0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) push_a(32'hA0 + 32'(i));
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (a_ax.tvalid && a_ax.tready) begin
        if (a_exp.size() == 0) begin
          errors++;
          $display("FAIL mid_extra_beat: got %h, want no beat", a_ax.tdata);
        end else begin
          exp = a_exp.pop_front();
          checks++;
          if (a_ax.tdata !== exp || a_ax.tlast !== (a_beat == 3)) begin
            errors++;
            $display("FAIL mid_post_data: got %h/%b want %h/%b", a_ax.tdata, a_ax.tlast, exp,
                     a_beat == 3);
          end
          a_beat = (a_beat + 1) % 4;
        end
      end
      tick();
    end
    checks++;
    if (a_exp.size() !== 0) begin
      errors++;
      $display("FAIL mid_timeout: %0d beats missing, want 0", a_exp.size());
    end
  endtask

  task automatic test_back_to_back();
    int first_re = -1;
    int first_v  = -1;
    int gaps     = 0;
    logic [31:0] exp;
    b_ax.tready = 1'b1;
    for (int i = 0; i < 20; i++) push_b(32'hB000 + 32'(i));
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (b_re && first_re < 0) first_re = cyc;
      if (b_ax.tvalid && first_v < 0) first_v = cyc;
      if (first_v >= 0 && b_exp.size() > 0 && !b_ax.tvalid) gaps++;
      if (b_ax.tvalid && b_ax.tready && b_exp.size() > 0) begin
        exp = b_exp.pop_front();
        checks++;
        if (b_ax.tdata !== exp || b_ax.tlast !== 1'b0) begin
          errors++;
          $display("FAIL b2b_data: got %h/%b want %h/0", b_ax.tdata, b_ax.tlast, exp);
        end
      end
      tick();
    end
    checks++;
    if (first_v - first_re !== 3 || gaps !== 0 || b_exp.size() !== 0) begin
      errors++;
      $display("FAIL b2b_rate: re@%0d valid@%0d gaps=%0d missing=%0d, want 3 apart 0 0",
               first_re, first_v, gaps, b_exp.size());
    end
  endtask

  task automatic test_random();
    int pushed = 0;
    int recv   = 0;
    int n;
    logic [31:0] exp;
    for (int cyc = 0; cyc < 8000 && recv < 1000; cyc++) begin
      b_ax.tready = 1'($urandom_range(0, 1));
      n = $urandom_range(0, 2);
      for (int k = 0; k < n && pushed < 1000; k++) begin
        push_b($urandom());
        pushed++;
      end
      @(negedge clk);
      checks++;
      if (b_cnt > 3'd4 || b_ax.tvalid !== (b_cnt != 3'd0)) begin
        errors++;
        $display("FAIL rnd_count: cnt=%0d v=%b, want <=4 and v=(cnt!=0)", b_cnt, b_ax.tvalid);
      end
      if (b_ax.tvalid && b_ax.tready) begin
        if (b_exp.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra_beat: got %h, want no beat", b_ax.tdata);
        end else begin
          exp = b_exp.pop_front();
          recv++;
          checks++;
          if (b_ax.tdata !== exp || b_ax.tlast !== 1'b0) begin
            errors++;
            $display("FAIL rnd_data: beat %0d got %h/%b want %h/0", recv, b_ax.tdata,
                     b_ax.tlast, exp);
          end
        end
      end
      tick();
    end
    checks++;
    if (recv !== 1000 || b_exp.size() !== 0 || b_uflow !== 1'b0) begin
      errors++;
      $display("FAIL rnd_total: recv=%0d missing=%0d underflow=%b, want 1000 0 0",
               recv, b_exp.size(), b_uflow);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_packets();
    test_rd_rst_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    checks++;
    if (a_uflow !== 1'b0) begin
      errors++;
      $display("FAIL a_underflow: got %b want 0", a_uflow);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
